// File: rtl/psram_write_queue_if.sv
// Host write port and PSRAM driver control port of the write queue, bundled.
// The queue uses the slave modport; the host/driver side uses master.
interface psram_write_queue_if #(
    parameter int ADDR_W = 24
);
    // Host side
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_address;
    logic [7:0]        wr_data;

    // PSRAM driver side
    logic              psram_enable;
    logic              psram_rw;
    logic              psram_set_address;
    logic              psram_write_data;
    logic [ADDR_W-1:0] psram_address;
    logic [7:0]        psram_data;
    logic              psram_next_byte_needed;

    modport master (
        output wr_valid,
        output wr_address,
        output wr_data,
        input  wr_ready,
        input  psram_enable,
        input  psram_rw,
        input  psram_set_address,
        input  psram_write_data,
        input  psram_address,
        input  psram_data,
        output psram_next_byte_needed
    );

    modport slave (
        input  wr_valid,
        input  wr_address,
        input  wr_data,
        output wr_ready,
        output psram_enable,
        output psram_rw,
        output psram_set_address,
        output psram_write_data,
        output psram_address,
        output psram_data,
        input  psram_next_byte_needed
    );
endinterface

// File: rtl/psram_write_queue.sv
// PSRAM write queue: buffers host byte writes in a small FIFO and replays them
// to the PSRAM driver, merging consecutive addresses into bursts that never
// cross a page boundary and never exceed MAX_BURST bytes.
module psram_write_queue #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 24,
    parameter int PAGE_BITS  = 10,
    parameter int MAX_BURST  = 32,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          sysclk,
    input  logic                          reset,
    psram_write_queue_if.slave            bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam int GCNT_W = $clog2(GAP_CYCLES + 2);

    localparam logic [CNT_W-1:0]  FULL_LEVEL = CNT_W'(FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] MAX_CNT    = BCNT_W'(MAX_BURST);
    localparam logic [GCNT_W-1:0] GAP_LAST   = GCNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_GAP
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } entry_t;

    // FIFO storage (small, read combinationally so the head can be compared
    // against the next burst address in the same cycle as the driver pulse)
    entry_t mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
    logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [GCNT_W-1:0] gap_cnt_q, gap_cnt_d;

    logic              enable_q, enable_d;
    logic              rw_q, rw_d;
    logic              set_addr_q, set_addr_d;
    logic              write_data_q, write_data_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [7:0]        data_q, data_d;

    logic              wr_ready_int;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    entry_t            head;
    logic [ADDR_W-1:0] next_addr;
    logic              can_continue;

    // Host-side acceptance: no bypass, a full queue refuses even if it pops this cycle
    always_comb begin
        wr_ready_int = (count_q != FULL_LEVEL) && !reset;
        push         = bus.wr_valid && wr_ready_int;
        fifo_empty   = (count_q == '0);
        head         = mem[rd_ptr_q];
    end

    // FIFO write port
    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{addr: bus.wr_address, data: bus.wr_data};
        end
    end

    // Burst sequencing: start on a non-empty queue, extend while the head is the
    // next sequential byte inside the same page and under the burst limit
    always_comb begin
        state_d      = state_q;
        burst_addr_d = burst_addr_q;
        burst_cnt_d  = burst_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        enable_d     = enable_q;
        rw_d         = rw_q;
        set_addr_d   = 1'b0;
        write_data_d = write_data_q;
        address_d    = address_q;
        data_d       = data_q;
        pop          = 1'b0;

        next_addr    = burst_addr_q + ADDR_W'(1);
        can_continue = (burst_cnt_q < MAX_CNT)
                    && (next_addr[PAGE_BITS-1:0] != '0)
                    && !fifo_empty
                    && (head.addr == next_addr);

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    burst_addr_d = head.addr;
                    address_d    = head.addr;
                    data_d       = head.data;
                    enable_d     = 1'b1;
                    rw_d         = 1'b1;
                    write_data_d = 1'b1;
                    set_addr_d   = 1'b1;
                    burst_cnt_d  = BCNT_W'(1);
                    state_d      = S_STREAM;
                end
            end
            S_STREAM: begin
                if (bus.psram_next_byte_needed) begin
                    if (can_continue) begin
                        pop          = 1'b1;
                        data_d       = head.data;
                        burst_addr_d = next_addr;
                        burst_cnt_d  = burst_cnt_q + BCNT_W'(1);
                    end else begin
                        enable_d     = 1'b0;
                        rw_d         = 1'b0;
                        write_data_d = 1'b0;
                        address_d    = '0;
                        data_d       = '0;
                        gap_cnt_d    = '0;
                        state_d      = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GCNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer and level bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // State and output registers; reset discards the queue and drops every output
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            burst_addr_q <= '0;
            burst_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            enable_q     <= 1'b0;
            rw_q         <= 1'b0;
            set_addr_q   <= 1'b0;
            write_data_q <= 1'b0;
            address_q    <= '0;
            data_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            burst_addr_q <= burst_addr_d;
            burst_cnt_q  <= burst_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            enable_q     <= enable_d;
            rw_q         <= rw_d;
            set_addr_q   <= set_addr_d;
            write_data_q <= write_data_d;
            address_q    <= address_d;
            data_q       <= data_d;
        end
    end

    // Output mapping
    always_comb begin
        bus.wr_ready          = wr_ready_int;
        bus.psram_enable      = enable_q;
        bus.psram_rw          = rw_q;
        bus.psram_set_address = set_addr_q;
        bus.psram_write_data  = write_data_q;
        bus.psram_address     = address_q;
        bus.psram_data        = data_q;
        fifo_level            = count_q;
        busy                  = (state_q != S_IDLE) || (count_q != '0);
    end
endmodule
